// File: rtl/lfsr_encrypt_ctrl_if.sv
// Bundle between the encryption sequencer and its surroundings: start/done handshake,
// shared data-memory port and lfsr6 control pins. master = sequencer, slave = environment.
interface lfsr_encrypt_ctrl_if;
  logic       start;
  logic       busy;
  logic       done;
  logic       err;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;
  logic       wr_en;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       lfsr_init;
  logic       lfsr_en;
  logic [5:0] lfsr_taps;
  logic [5:0] lfsr_start;
  logic [5:0] lfsr_state;

  modport master (
    input  start, rd_data, lfsr_state,
    output busy, done, err, rd_addr, wr_en, wr_addr, wr_data,
           lfsr_init, lfsr_en, lfsr_taps, lfsr_start
  );

  modport slave (
    output start, rd_data, lfsr_state,
    input  busy, done, err, rd_addr, wr_en, wr_addr, wr_data,
           lfsr_init, lfsr_en, lfsr_taps, lfsr_start
  );
endinterface

// File: rtl/lfsr_encrypt_ctrl.sv
// Reads tap/preamble/seed config, loads lfsr6, then encrypts 64 chars to OUT_BASE.. (one write per 2 cycles).
// Start-to-done is 134 cycles; no backpressure, start is only sampled in IDLE.
module lfsr_encrypt_ctrl #(
  parameter int MSG_LEN  = 50,
  parameter int OUT_BASE = 64
) (
  input logic                 clk,
  input logic                 rst_n,
  lfsr_encrypt_ctrl_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_CFG, S_LOAD, S_RUN, S_DONE} state_t;

  state_t     state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic [5:0] taps_q, taps_d;
  logic [3:0] plen_q, plen_d;
  logic [5:0] seed_q, seed_d;
  logic       err_q, err_d;

  logic [5:0] k;
  logic       phase_b;
  logic [6:0] msg_idx;
  logic       is_msg;
  logic [5:0] ch_off;
  logic       unused_rd_hi;

  // In RUN the counter holds {k, phase}; in CFG its low two bits are the config cycle.
  assign k       = cnt_q[6:1];
  assign phase_b = cnt_q[0];
  assign msg_idx = {1'b0, k} - {3'b000, plen_q};
  assign is_msg  = ({1'b0, k} >= {3'b000, plen_q}) && (msg_idx < 7'(MSG_LEN));
  assign ch_off  = is_msg ? (bus.rd_data[5:0] - 6'h20) : 6'h00;
  assign unused_rd_hi = ^bus.rd_data[7:6];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      taps_q  <= '0;
      plen_q  <= '0;
      seed_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      taps_q  <= taps_d;
      plen_q  <= plen_d;
      seed_q  <= seed_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    taps_d  = taps_q;
    plen_d  = plen_q;
    seed_d  = seed_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_CFG;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_CFG: begin
        cnt_d = cnt_q + 7'd1;
        case (cnt_q[1:0])
          2'd1: begin
            case (bus.rd_data[2:0])
              3'd0:    taps_d = 6'h21;
              3'd1:    taps_d = 6'h2D;
              3'd2:    taps_d = 6'h30;
              3'd3:    taps_d = 6'h33;
              3'd4:    taps_d = 6'h36;
              3'd5:    taps_d = 6'h39;
              default: begin
                taps_d = 6'h21;
                err_d  = 1'b1;
              end
            endcase
          end
          2'd2: begin
            if (bus.rd_data[3:0] < 4'd7) begin
              plen_d = 4'd7;
              err_d  = 1'b1;
            end else if (bus.rd_data[3:0] > 4'd12) begin
              plen_d = 4'd12;
              err_d  = 1'b1;
            end else begin
              plen_d = bus.rd_data[3:0];
            end
          end
          2'd3: begin
            if (bus.rd_data[5:0] == 6'd0) begin
              seed_d = 6'h01;
              err_d  = 1'b1;
            end else begin
              seed_d = bus.rd_data[5:0];
            end
            state_d = S_LOAD;
            cnt_d   = '0;
          end
          default: ;
        endcase
      end
      S_LOAD: state_d = S_RUN;
      S_RUN: begin
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == 7'd127) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.rd_addr   = '0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.lfsr_init = 1'b0;
    bus.lfsr_en   = 1'b0;
    case (state_q)
      S_CFG: begin
        bus.busy = 1'b1;
        if (cnt_q[1:0] != 2'd3) bus.rd_addr = 7'd61 + {5'd0, cnt_q[1:0]};
      end
      S_LOAD: begin
        bus.busy      = 1'b1;
        bus.lfsr_init = 1'b1;
      end
      S_RUN: begin
        bus.busy = 1'b1;
        if (!phase_b) begin
          if (is_msg) bus.rd_addr = msg_idx;
        end else begin
          bus.wr_en   = 1'b1;
          bus.wr_addr = 7'(OUT_BASE) + {1'b0, k};
          bus.wr_data = {2'b00, ch_off ^ bus.lfsr_state};
          bus.lfsr_en = 1'b1;
        end
      end
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.err        = err_q;
  assign bus.lfsr_taps  = taps_q;
  assign bus.lfsr_start = seed_q;

endmodule

// File: tb/tb_lfsr_encrypt_ctrl.sv
// Bench for lfsr_encrypt_ctrl with a stand-in data memory and lfsr6; expected writes are
// queued per run from the config rules and popped by a falling-edge monitor.
module tb_lfsr_encrypt_ctrl;
  localparam int MSG_LEN  = 50;
  localparam int OUT_BASE = 64;

  logic clk = 1'b0;
  logic rst_n;
  lfsr_encrypt_ctrl_if bus();

  lfsr_encrypt_ctrl #(.MSG_LEN(MSG_LEN), .OUT_BASE(OUT_BASE)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem  [0:127];
  logic [7:0]  seen [0:127];
  logic [7:0]  pre_exp [0:6];
  logic [5:0]  lfsr_q = 6'd0;
  logic [14:0] exp_q [$];
  logic        exp_err = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  // lfsr6 stand-in: shift left, XNOR feedback of the tapped bits above bit 0.
  function automatic logic [5:0] lfsr_next(input logic [5:0] s, input logic [5:0] taps);
    return {s[4:0], ~^(s & (taps & 6'h3E))};
  endfunction

  function automatic logic [5:0] taps_of(input logic [2:0] sel);
    case (sel)
      3'd1:    return 6'h2D;
      3'd2:    return 6'h30;
      3'd3:    return 6'h33;
      3'd4:    return 6'h36;
      3'd5:    return 6'h39;
      default: return 6'h21;
    endcase
  endfunction

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    end
  endfunction

  function automatic logic [63:0] outs();
    return {24'd0, bus.busy, bus.done, bus.err, bus.rd_addr, bus.wr_en, bus.wr_addr,
            bus.wr_data, bus.lfsr_init, bus.lfsr_en, bus.lfsr_taps, bus.lfsr_start};
  endfunction

  always @(posedge clk) begin
    bus.rd_data <= mem[bus.rd_addr];
    if (bus.lfsr_init)    lfsr_q <= bus.lfsr_start;
    else if (bus.lfsr_en) lfsr_q <= lfsr_next(lfsr_q, bus.lfsr_taps);
  end
  assign bus.lfsr_state = lfsr_q;

  task automatic set_cfg(input logic [2:0] sel, input logic [3:0] p, input logic [5:0] seed, input int mode);
    for (int i = 0; i < 61; i++) mem[i] = (mode == 2) ? 8'($urandom_range(0, 255)) : 8'h20;
    if (mode == 1) mem[0] = 8'h41;
    mem[61] = {5'($urandom), sel};
    mem[62] = {4'($urandom), p};
    mem[63] = {2'($urandom), seed};
  endtask

  // Expected 64 writes of one run, straight from the config and character rules.
  task automatic push_expected();
    logic [2:0] sel;
    logic [5:0] seed, taps, st, d;
    logic [7:0] ch;
    int p;
    exp_err = 1'b0;
    sel  = mem[61][2:0];
    p    = int'(mem[62][3:0]);
    seed = mem[63][5:0];
    if (sel > 3'd5) begin sel = 3'd0; exp_err = 1'b1; end
    if (p < 7) begin p = 7; exp_err = 1'b1; end
    else if (p > 12) begin p = 12; exp_err = 1'b1; end
    if (seed == 6'd0) begin seed = 6'h01; exp_err = 1'b1; end
    taps = taps_of(sel);
    st   = seed;
    for (int k = 0; k < 64; k++) begin
      ch = (k >= p && k < p + MSG_LEN) ? mem[k - p] : 8'h20;
      d  = 6'(ch - 8'h20) ^ st;
      exp_q.push_back({7'(OUT_BASE + k), 2'b00, d});
      st = lfsr_next(st, taps);
    end
  endtask

  task automatic monitor();
    logic [14:0] e;
    forever begin
      @(negedge clk);
      if (!bus.wr_en) chk("lfsr_en_outside_write", bus.lfsr_en, 0);
      else begin
        chk("lfsr_en_on_write", bus.lfsr_en, 1);
        chk("write_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("wr_addr", bus.wr_addr, e[14:8]);
          chk("wr_data", bus.wr_data, e[7:0]);
          seen[bus.wr_addr] = bus.wr_data;
        end
      end
    end
  endtask

  // Called right after the edge that accepted start (E0).
  task automatic time_run(input bit drop_start, input bit pulse_mid);
    int busy_n = 0;
    int done_cyc = -1;
    int first_wr = -1;
    for (int cyc = 1; cyc <= 300 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        chk("err_clear_on_start", bus.err, 0);
        if (drop_start) bus.start = 1'b0;
      end
      if (pulse_mid && cyc == 60) bus.start = 1'b1;
      if (pulse_mid && cyc == 61) bus.start = 1'b0;
      if (bus.busy) busy_n++;
      if (bus.wr_en && first_wr < 0) first_wr = cyc;
      if (bus.done) done_cyc = cyc;
    end
    chk("busy_cycles", busy_n, 133);
    chk("done_cycle", done_cyc, 134);
    chk("first_write_cycle", first_wr, 7);
  endtask

  task automatic launch(input bit hold, input bit pulse_mid);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    time_run(!hold, pulse_mid);
  endtask

  task automatic post_idle(input int window);
    int dn = 0;
    for (int i = 0; i < window; i++) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    chk("extra_done", dn, 0);
    chk("writes_drained", exp_q.size(), 0);
    chk("err_flag", bus.err, exp_err);
    chk("busy_idle", bus.busy, 0);
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 128; i++) begin
      mem[i]  = 8'h00;
      seen[i] = 8'h00;
    end
    pre_exp[0] = 8'h01; pre_exp[1] = 8'h03; pre_exp[2] = 8'h07; pre_exp[3] = 8'h0F;
    pre_exp[4] = 8'h1F; pre_exp[5] = 8'h3F; pre_exp[6] = 8'h3E;
    bus.start = 1'b0;
    rst_n     = 1'b1;
    #3 rst_n = 1'b0;
    #1 chk("reset_outputs", outs(), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    fork
      monitor();
    join_none

    // Defaults, all-space message: outputs are the raw LFSR states.
    set_cfg(3'd0, 4'd7, 6'h01, 0);
    push_expected();
    launch(0, 0);
    post_idle(4);
    for (int i = 0; i < 7; i++) chk($sformatf("preamble_out%0d", i), seen[OUT_BASE + i], pre_exp[i]);

    set_cfg(3'd0, 4'd7, 6'h01, 1);
    push_expected();
    launch(0, 0);
    post_idle(4);
    chk("msg_A_out7", seen[OUT_BASE + 7], 8'h1D);

    // Lower clamps on all three fields, then the upper preamble clamp.
    set_cfg(3'd7, 4'd3, 6'h00, 2);
    push_expected();
    launch(0, 0);
    post_idle(10);
    chk("clamp_err_held", bus.err, 1);

    set_cfg(3'd2, 4'd15, 6'h2A, 2);
    push_expected();
    launch(0, 0);
    post_idle(4);

    for (int r = 0; r < 8; r++) begin
      set_cfg(3'(r), 4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)), 2);
      push_expected();
      launch(0, 0);
      post_idle(3);
    end

    // A start pulse mid-run must not restart or add a second done.
    set_cfg(3'($urandom_range(0, 5)), 4'($urandom_range(7, 12)), 6'($urandom_range(1, 63)), 2);
    push_expected();
    launch(0, 1);
    post_idle(150);

    // Start held high through DONE: two identical back-to-back runs.
    set_cfg(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)), 2);
    push_expected();
    push_expected();
    launch(1, 0);
    @(posedge clk);
    @(posedge clk);
    time_run(1, 0);
    post_idle(4);

    // Reset at k=20, then a fresh run on the same config.
    set_cfg(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)), 2);
    push_expected();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (bus.wr_en && bus.wr_addr == 7'(OUT_BASE + 20)) found = 1'b1;
    end
    chk("reach_k20", found, 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1 chk("reset_mid_outputs", outs(), 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    push_expected();
    launch(0, 0);
    post_idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
